timer_wb: RTL and testbench
===========================

TIMER_WB -- requirements
Module: timer_wb

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, giving the prescaler register and counter width in bits (1..32).
REQ-002 SHALL have parameter CMP_RESET, default 64'hFFFF_FFFF_FFFF_FFFF, giving the reset value of MTIMECMP.
REQ-003 SHALL have port wb_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port wb_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port wb_adr, input, 32 bits: byte address; only bits [4:2] are decoded.
REQ-006 SHALL have port wb_dat, input, 32 bits: write data.
REQ-007 SHALL have port wb_sel, input, 4 bits: byte enables for writes.
REQ-008 SHALL have port wb_we, input, 1 bit: write enable.
REQ-009 SHALL have ports wb_cyc and wb_stb, inputs, 1 bit each: Wishbone classic cycle and strobe.
REQ-010 SHALL have port wb_rdt, output, 32 bits: read data.
REQ-011 SHALL have port wb_ack, output, 1 bit: transfer acknowledge.
REQ-012 SHALL have port timer_irq, output, 1 bit: level interrupt, wired to the core's interrupt_timer input.

Function
REQ-013 SHALL decode the register map on wb_adr[4:2]: 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 EN, other bits read 0), 5 PRESCALE ([PRESCALE_W-1:0]).
REQ-014 SHALL treat a request as req = wb_cyc & wb_stb & ~wb_ack.
- wb_ack is registered and high exactly one cycle after req.
- A strobe held through the ack cycle is not re-acked, so acks are at most every other cycle.
REQ-015 SHALL present wb_rdt in the same cycle as wb_ack, and SHALL drive wb_rdt to 0 whenever wb_ack is low.
REQ-016 SHALL apply writes on the req cycle, per byte lane under wb_sel; lanes with wb_sel bit low are unchanged.
REQ-017 SHALL acknowledge writes to unmapped offsets 6 and 7 without changing any state, and SHALL return 0 on reads of them.
REQ-018 SHALL implement the prescaler with a PRESCALE_W-bit counter pcnt.
- While EN=1, pcnt increments each cycle.
- When pcnt == PRESCALE, pcnt returns to 0 and a one-cycle tick fires.
- PRESCALE=0 therefore ticks every cycle.
REQ-019 SHALL hold pcnt and MTIME frozen while EN=0, and SHALL clear pcnt on an EN 0->1 write.
REQ-020 SHALL increment the 64-bit MTIME by 1 on each tick, wrapping from 2^64-1 to 0 with no flag.
REQ-021 SHALL give a bus write to MTIME_LO or MTIME_HI priority over a same-cycle tick; the whole 64-bit MTIME does not increment in that cycle.
REQ-022 SHALL clear pcnt in the same cycle as a write to PRESCALE.
REQ-023 SHALL make 64-bit reads atomic: a read of MTIME_LO copies MTIME[63:32] into a 32-bit shadow in the same cycle, and a read of MTIME_HI returns the shadow.
REQ-024 SHALL compute timer_irq as a register: timer_irq <= EN & (MTIME >= MTIMECMP), an unsigned 64-bit compare, giving one cycle of latency after the condition changes.
REQ-025 SHALL drop timer_irq on the cycle after a write that makes MTIMECMP > MTIME or clears EN.

Reset
REQ-026 SHALL, while wb_rst=1, set MTIME=0, MTIMECMP=CMP_RESET, EN=0, PRESCALE=0, pcnt=0, shadow=0, wb_ack=0, wb_rdt=0 and timer_irq=0.
REQ-027 SHALL, when wb_rst is asserted mid-transfer, drop the pending ack and discard the pending write; the master must reissue the transfer.

Structure
REQ-028 SHALL place the register offset constants (MTIME_LO..PRESCALE) and the CTRL bit index in the shared SoC package; the interconnect decode stays outside this block.
REQ-029 SHALL contain one sub-module, timer_prescaler, holding pcnt and producing tick from EN and PRESCALE; the bus logic, MTIME, compare and shadow remain in timer_wb.

Verification
REQ-030 SHALL cover the following directed scenarios in the bench:
- Reset, then read all six offsets -> MTIME=0, MTIMECMP_LO/HI=0xFFFFFFFF, CTRL=0, PRESCALE=0; timer_irq=0; each ack exactly one cycle after stb.
- PRESCALE=3, EN=1, wait 40 cycles -> MTIME=10 (±1 by alignment); ticks exactly 4 cycles apart.
- MTIME write 0x0000_0000_FFFF_FFFE, EN=1, PRESCALE=0, read LO then HI across the carry -> LO/HI pair is consistent (either 0xFFFFFFFF/0x0 or 0x1/0x1, never mixed).
- MTIMECMP=20, EN=1, PRESCALE=0 -> timer_irq rises on the cycle after MTIME reaches 20; writing MTIMECMP_HI=1 drops it on the next cycle.
- Write MTIME_LO=0x55 with wb_sel=4'b0001 in the same cycle as a tick -> MTIME_LO[7:0]=0x55, upper bytes unchanged, no increment that cycle.
- wb_rst pulsed during a pending write ack -> no ack, register unchanged, all outputs at reset values.

Source files
------------

// File: rtl/timer_wb_pkg.sv
// Shared SoC definitions for the Wishbone machine timer: register offsets,
// CTRL bit positions and the byte-lane write helper.
package timer_wb_pkg;

  typedef logic [2:0] reg_off_t;

  localparam reg_off_t OFF_MTIME_LO    = 3'd0;
  localparam reg_off_t OFF_MTIME_HI    = 3'd1;
  localparam reg_off_t OFF_MTIMECMP_LO = 3'd2;
  localparam reg_off_t OFF_MTIMECMP_HI = 3'd3;
  localparam reg_off_t OFF_CTRL        = 3'd4;
  localparam reg_off_t OFF_PRESCALE    = 3'd5;

  localparam int CTRL_EN_BIT = 0;

  // Replace the bytes of old selected by sel with the matching bytes of dat.
  function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                             input logic [31:0] dat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        res[8*i +: 8] = dat[8*i +: 8];
      end else begin
        res[8*i +: 8] = old[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/timer_wb_prescaler.sv
// Prescaler for the machine timer: counts enabled cycles and emits a
// one-cycle tick each time the count reaches the programmed limit.
module timer_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pcnt;
  logic                  at_limit;

  assign at_limit = (pcnt == prescale);
  assign tick     = en & at_limit;

  // Prescale counter; a clear request wins over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (clr) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= at_limit ? '0 : pcnt + PRESCALE_W'(1'b1);
    end
  end

endmodule

// File: rtl/timer_wb.sv
// RISC-V style machine timer (MTIME/MTIMECMP) on a Wishbone classic slave port
// with a programmable prescaler and a level timer interrupt.
module timer_wb
  import timer_wb_pkg::*;
#(
  parameter int          PRESCALE_W = 16,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat,
  input  logic [3:0]  wb_sel,
  input  logic        wb_we,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  output logic [31:0] wb_rdt,
  output logic        wb_ack,
  output logic        timer_irq
);

  logic [63:0]           mtime;
  logic [63:0]           mtimecmp;
  logic                  en;
  logic [PRESCALE_W-1:0] prescale;
  logic [31:0]           shadow;
  logic                  tick;
  logic                  pcnt_clr;

  logic                  req;
  logic                  rd;
  logic                  wr;
  reg_off_t              off;
  logic [31:0]           rd_data;

  logic wr_mtime_lo;
  logic wr_mtime_hi;
  logic wr_cmp_lo;
  logic wr_cmp_hi;
  logic wr_ctrl;
  logic wr_prescale;
  logic unused_adr;

  assign req = wb_cyc & wb_stb & ~wb_ack;
  assign rd  = req & ~wb_we;
  assign wr  = req & wb_we;
  assign off = wb_adr[4:2];

  assign unused_adr = ^{wb_adr[31:5], wb_adr[1:0]};

  assign wr_mtime_lo = wr & (off == OFF_MTIME_LO);
  assign wr_mtime_hi = wr & (off == OFF_MTIME_HI);
  assign wr_cmp_lo   = wr & (off == OFF_MTIMECMP_LO);
  assign wr_cmp_hi   = wr & (off == OFF_MTIMECMP_HI);
  assign wr_ctrl     = wr & (off == OFF_CTRL);
  assign wr_prescale = wr & (off == OFF_PRESCALE);

  // Restart the prescale phase on a new limit or when the timer is switched on.
  assign pcnt_clr = wr_prescale
                  | (wr_ctrl & wb_sel[CTRL_EN_BIT/8] & wb_dat[CTRL_EN_BIT] & ~en);

  timer_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk      (wb_clk),
    .rst      (wb_rst),
    .en       (en),
    .clr      (pcnt_clr),
    .prescale (prescale),
    .tick     (tick)
  );

  // Read data mux; MTIME_HI returns the value latched by the last MTIME_LO read.
  always_comb begin
    rd_data = 32'h0000_0000;
    case (off)
      OFF_MTIME_LO:    rd_data = mtime[31:0];
      OFF_MTIME_HI:    rd_data = shadow;
      OFF_MTIMECMP_LO: rd_data = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rd_data = mtimecmp[63:32];
      OFF_CTRL:        rd_data[CTRL_EN_BIT] = en;
      OFF_PRESCALE:    rd_data = 32'(prescale);
      default:         rd_data = 32'h0000_0000;
    endcase
  end

  // Bus response: one-cycle ack after each request, data only alongside it.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      wb_ack <= 1'b0;
      wb_rdt <= 32'h0000_0000;
    end else begin
      wb_ack <= req;
      wb_rdt <= rd ? rd_data : 32'h0000_0000;
    end
  end

  // High-word snapshot taken on every MTIME_LO read.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      shadow <= 32'h0000_0000;
    end else if (rd && (off == OFF_MTIME_LO)) begin
      shadow <= mtime[63:32];
    end
  end

  // MTIME: a bus write to either half suppresses that cycle's tick.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      mtime <= 64'h0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= byte_merge(mtime[31:0], wb_dat, wb_sel);
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= byte_merge(mtime[63:32], wb_dat, wb_sel);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Compare value, enable and prescale limit registers.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      mtimecmp <= CMP_RESET;
      en       <= 1'b0;
      prescale <= '0;
    end else begin
      if (wr_cmp_lo) begin
        mtimecmp[31:0] <= byte_merge(mtimecmp[31:0], wb_dat, wb_sel);
      end
      if (wr_cmp_hi) begin
        mtimecmp[63:32] <= byte_merge(mtimecmp[63:32], wb_dat, wb_sel);
      end
      if (wr_ctrl && wb_sel[CTRL_EN_BIT/8]) begin
        en <= wb_dat[CTRL_EN_BIT];
      end
      if (wr_prescale) begin
        prescale <= PRESCALE_W'(byte_merge(32'(prescale), wb_dat, wb_sel));
      end
    end
  end

  // Interrupt level follows the registered compare result.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= en & (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_timer_wb.sv
// Self-checking bench for timer_wb: register table, directed timing
// sequences and a randomized run against a cycle-level behavioural model.
module tb_timer_wb;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        timer_irq;

  always #5 wb_clk = ~wb_clk;

  timer_wb dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .wb_adr    (wb_adr),
    .wb_dat    (wb_dat),
    .wb_sel    (wb_sel),
    .wb_we     (wb_we),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_rdt    (wb_rdt),
    .wb_ack    (wb_ack),
    .timer_irq (timer_irq)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (what the registers should hold in the current cycle)
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic [15:0] m_pre;
  logic [15:0] m_pcnt;
  logic [31:0] m_shadow;
  logic        m_ack;
  logic [31:0] m_rdt;
  logic        m_irq;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  // Advance the model by one clock using the currently driven inputs, clock
  // the DUT, and compare all outputs just after the edge.
  task automatic step();
    logic        req;
    logic        tk;
    logic [2:0]  off;
    logic [31:0] mrg;
    logic [63:0] n_mtime;
    logic [15:0] n_pcnt;
    logic [31:0] n_shadow;
    logic [31:0] n_rdt;
    off = wb_adr[4:2];
    if (wb_rst) begin
      m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 1'b0; m_pre = 16'd0;
      m_pcnt = 16'd0; m_shadow = 32'd0; m_ack = 1'b0; m_rdt = 32'd0; m_irq = 1'b0;
    end else begin
      req      = wb_cyc && wb_stb && !m_ack;
      m_irq    = m_en && (m_mtime >= m_cmp);
      tk       = m_en && (m_pcnt == m_pre);
      n_mtime  = tk ? m_mtime + 64'd1 : m_mtime;
      n_pcnt   = !m_en ? m_pcnt : (tk ? 16'd0 : m_pcnt + 16'd1);
      n_shadow = m_shadow;
      n_rdt    = 32'd0;
      if (req && !wb_we) begin
        case (off)
          3'd0: begin n_rdt = m_mtime[31:0]; n_shadow = m_mtime[63:32]; end
          3'd1: n_rdt = m_shadow;
          3'd2: n_rdt = m_cmp[31:0];
          3'd3: n_rdt = m_cmp[63:32];
          3'd4: n_rdt = {31'd0, m_en};
          3'd5: n_rdt = {16'd0, m_pre};
          default: n_rdt = 32'd0;
        endcase
      end
      if (req && wb_we) begin
        case (off)
          3'd0: n_mtime = {m_mtime[63:32], merge(m_mtime[31:0], wb_dat, wb_sel)};
          3'd1: n_mtime = {merge(m_mtime[63:32], wb_dat, wb_sel), m_mtime[31:0]};
          3'd2: m_cmp[31:0]  = merge(m_cmp[31:0], wb_dat, wb_sel);
          3'd3: m_cmp[63:32] = merge(m_cmp[63:32], wb_dat, wb_sel);
          3'd4: if (wb_sel[0]) begin
                  if (wb_dat[0] && !m_en) n_pcnt = 16'd0;
                  m_en = wb_dat[0];
                end
          3'd5: begin
                  mrg = merge({16'd0, m_pre}, wb_dat, wb_sel);
                  m_pre = mrg[15:0];
                  n_pcnt = 16'd0;
                end
          default: ;
        endcase
      end
      m_mtime = n_mtime; m_pcnt = n_pcnt; m_shadow = n_shadow; m_rdt = n_rdt; m_ack = req;
    end
    @(posedge wb_clk);
    #1;
    chk("model_ack", wb_ack, m_ack);
    chk("model_rdt", wb_rdt, m_rdt);
    chk("model_irq", timer_irq, m_irq);
  endtask

  task automatic bus(input logic we, input logic [2:0] off, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rdt);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
    wb_adr = {27'd0, off, 2'b00}; wb_dat = dat; wb_sel = sel;
    chk("ack_before_req", wb_ack, 1'b0);
    step();
    chk("ack_one_cycle", wb_ack, 1'b1);
    rdt = wb_rdt;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    step();
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] dat);
    logic [31:0] d;
    bus(1'b1, off, dat, 4'hF, d);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        seen;

    wb_rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = 32'd0; wb_dat = 32'd0; wb_sel = 4'h0;

    // Reset state
    repeat (3) step();
    chk("rst_ack", wb_ack, 1'b0);
    chk("rst_rdt", wb_rdt, 32'd0);
    chk("rst_irq", timer_irq, 1'b0);
    wb_rst = 1'b0;
    step();

    // Register table: reset values, unmapped offsets, byte lanes, PRESCALE width
    tbl[0]  = '{1'b0, 3'd0, 32'h0, 4'hF, 32'h0000_0000};
    tbl[1]  = '{1'b0, 3'd1, 32'h0, 4'hF, 32'h0000_0000};
    tbl[2]  = '{1'b0, 3'd2, 32'h0, 4'hF, 32'hFFFF_FFFF};
    tbl[3]  = '{1'b0, 3'd3, 32'h0, 4'hF, 32'hFFFF_FFFF};
    tbl[4]  = '{1'b0, 3'd4, 32'h0, 4'hF, 32'h0000_0000};
    tbl[5]  = '{1'b0, 3'd5, 32'h0, 4'hF, 32'h0000_0000};
    tbl[6]  = '{1'b0, 3'd6, 32'h0, 4'hF, 32'h0000_0000};
    tbl[7]  = '{1'b0, 3'd7, 32'h0, 4'hF, 32'h0000_0000};
    tbl[8]  = '{1'b1, 3'd6, 32'h0000_0000, 4'hF, 32'h0};
    tbl[9]  = '{1'b1, 3'd7, 32'h1234_5678, 4'hF, 32'h0};
    tbl[10] = '{1'b0, 3'd2, 32'h0, 4'hF, 32'hFFFF_FFFF};
    tbl[11] = '{1'b1, 3'd2, 32'h1234_5678, 4'b0101, 32'h0};
    tbl[12] = '{1'b0, 3'd2, 32'h0, 4'hF, 32'hFF34_FF78};
    tbl[13] = '{1'b1, 3'd4, 32'hFFFF_FFFE, 4'b0001, 32'h0};
    tbl[14] = '{1'b0, 3'd4, 32'h0, 4'hF, 32'h0000_0000};
    tbl[15] = '{1'b1, 3'd5, 32'hABCD_1234, 4'b1100, 32'h0};
    tbl[16] = '{1'b0, 3'd5, 32'h0, 4'hF, 32'h0000_0000};
    tbl[17] = '{1'b1, 3'd5, 32'h0000_1203, 4'b0011, 32'h0};
    tbl[18] = '{1'b0, 3'd5, 32'h0, 4'hF, 32'h0000_1203};
    tbl[19] = '{1'b1, 3'd2, 32'hFFFF_FFFF, 4'hF, 32'h0};
    for (int i = 0; i < 20; i++) begin
      bus(tbl[i].we, tbl[i].off, tbl[i].dat, tbl[i].sel, v);
      if (!tbl[i].we) chk($sformatf("table_rd[%0d]", i), v, tbl[i].exp);
    end

    // PRESCALE=3: about 10 ticks in 40 cycles, and exactly 10 per 40-cycle window
    wr(3'd5, 32'd3);
    wr(3'd4, 32'd1);
    repeat (38) step();
    bus(1'b0, 3'd0, 32'd0, 4'hF, a);
    chk("mtime_40cyc_in_range", (a >= 32'd9) && (a <= 32'd11), 1'b1);
    repeat (38) step();
    bus(1'b0, 3'd0, 32'd0, 4'hF, v);
    chk("ticks_per_40cyc", v - a, 32'd10);

    // Atomic 64-bit read across a low-word carry
    wr(3'd5, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'hFFFF_FFFD);
    bus(1'b0, 3'd0, 32'd0, 4'hF, lo);
    bus(1'b0, 3'd1, 32'd0, 4'hF, hi);
    chk("carry_pair_lo", lo, 32'hFFFF_FFFE);
    chk("carry_pair_hi", hi, 32'h0000_0000);
    bus(1'b0, 3'd0, 32'd0, 4'hF, lo);
    bus(1'b0, 3'd1, 32'd0, 4'hF, hi);
    chk("pair_consistent", (lo >= 32'hFFFF_FFF0) ? (hi == 32'd0) : (hi == 32'd1), 1'b1);

    // Compare interrupt: rise one cycle after MTIME reaches 20, drop after CMP_HI write
    wr(3'd4, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd20);
    chk("irq_idle", timer_irq, 1'b0);
    wr(3'd4, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      seen = timer_irq;
    end
    chk("irq_rise_seen", seen, 1'b1);
    bus(1'b0, 3'd0, 32'd0, 4'hF, v);
    chk("mtime_at_irq_rise", v, 32'd21);
    chk("irq_held", timer_irq, 1'b1);
    wr(3'd3, 32'd1);
    chk("irq_drop_after_cmp", timer_irq, 1'b0);

    // Partial MTIME_LO write coinciding with a tick
    wr(3'd4, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'hAABB_CC00);
    wr(3'd4, 32'd1);
    bus(1'b1, 3'd0, 32'h0000_0055, 4'b0001, v);
    bus(1'b0, 3'd0, 32'd0, 4'hF, v);
    chk("byte_write_vs_tick", v, 32'hAABB_CC56);
    bus(1'b0, 3'd1, 32'd0, 4'hF, v);
    chk("byte_write_hi", v, 32'd0);

    // Reset arriving with a pending write
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
    wb_adr = {27'd0, 3'd2, 2'b00}; wb_dat = 32'h0000_1234; wb_sel = 4'hF;
    wb_rst = 1'b1;
    step();
    chk("rst_pending_ack", wb_ack, 1'b0);
    chk("rst_pending_rdt", wb_rdt, 32'd0);
    chk("rst_pending_irq", timer_irq, 1'b0);
    wb_rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    step();
    bus(1'b0, 3'd2, 32'd0, 4'hF, v);
    chk("rst_discarded_write", v, 32'hFFFF_FFFF);
    bus(1'b0, 3'd0, 32'd0, 4'hF, v);
    chk("rst_mtime", v, 32'd0);
    bus(1'b0, 3'd4, 32'd0, 4'hF, v);
    chk("rst_ctrl", v, 32'd0);

    // Randomized traffic: every cycle independent, checked against the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0]  off;
      logic [26:0] up;
      off    = 3'($urandom_range(0, 7));
      up     = 27'($urandom());
      wb_rst = ($urandom_range(0, 299) == 0);
      wb_cyc = ($urandom_range(0, 3) != 0);
      wb_stb = 1'($urandom_range(0, 1));
      wb_we  = ($urandom_range(0, 2) == 0);
      wb_adr = {up, off, 2'($urandom_range(0, 3))};
      wb_sel = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
      case (off)
        3'd0, 3'd2: wb_dat = 32'($urandom_range(0, 300));
        3'd1, 3'd3: wb_dat = 32'($urandom_range(0, 1));
        3'd4:       wb_dat = {31'($urandom()), ($urandom_range(0, 3) != 0)};
        3'd5:       wb_dat = 32'($urandom_range(0, 2));
        default:    wb_dat = $urandom();
      endcase
      step();
    end

    wb_rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
